// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - copies a KB*1024-byte registered ROM to a destination bus, one byte per handshake
module rom_loader #(
  parameter int          KB   = 0,
  parameter logic [21:0] BASE = 22'h000000,
  localparam int         AW   = (KB < 1) ? 1 : $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] ra,
  input  logic [7:0]    rq,
  output logic          wr,
  output logic [21:0]   wa,
  output logic [7:0]    wd,
  input  logic          ack,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST = AW'(KB * 1024 - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, WRITE, DONE} state_t;

  state_t        state;
  logic [AW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ra    <= '0;
      count <= '0;
      wa    <= '0;
      wd    <= '0;
      wr    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= '0;
            count <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        // ra is held this edge so the ROM output register captures mem[ra]
        FETCH: state <= LATCH;
        LATCH: begin
          wd    <= rq;
          wa    <= BASE + 22'(count);
          wr    <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          if (ack) begin
            wr <= 1'b0;
            if (count == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              count <= count + 1'b1;
              ra    <= ra + 1'b1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - table and scoreboard bench for rom_loader
module tb_rom_loader;
  localparam int          KB   = 1;
  localparam int          N    = KB * 1024;
  localparam logic [21:0] BASE = 22'h010000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ack   = 1'b1;
  logic [9:0]  ra;
  logic [7:0]  rq;
  logic        wr, busy, done;
  logic [21:0] wa;
  logic [7:0]  wd;

  always #5 clock = ~clock;

  rom_loader #(.KB(KB), .BASE(BASE)) dut (
    .clock(clock), .reset(reset), .start(start), .ra(ra), .rq(rq),
    .wr(wr), .wa(wa), .wd(wd), .ack(ack), .busy(busy), .done(done)
  );

  // registered single-port ROM, mem[i] = i[7:0] ^ 8'h5A
  always @(posedge clock) rq <= ra[7:0] ^ 8'h5A;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int transfers = 0;
  int byte_cnt [N];

  typedef struct {
    logic [21:0] wa;
    logic [7:0]  wd;
  } xfer_t;
  xfer_t sbq[$];

  typedef struct {
    int   off;
    logic wr;
    logic busy;
    logic done;
    int   ra;
  } tv_t;
  tv_t tbl [8];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // transfer happens on the next rising edge when wr and ack are both high here
  always @(negedge clock) begin
    if (reset && wr && ack) begin
      xfer_t e;
      int idx;
      transfers++;
      idx = int'(wa) - int'(BASE);
      if (idx >= 0 && idx < N) byte_cnt[idx]++;
      if (sbq.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sbq.pop_front();
        chk("xfer_wa", int'(wa), int'(e.wa));
        chk("xfer_wd", int'(wd), int'(e.wd));
      end
    end
  end

  task automatic push_copy();
    sbq.delete();
    transfers = 0;
    for (int i = 0; i < N; i++) begin
      byte_cnt[i] = 0;
      sbq.push_back('{BASE + 22'(i), 8'(i) ^ 8'h5A});
    end
  endtask

  task automatic start_copy(output int t0);
    push_copy();
    start = 1'b1;
    @(posedge clock);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic run_table(input int t0);
    for (int i = 0; i < 8; i++) begin
      do @(negedge clock); while (cyc < t0 + tbl[i].off);
      chk($sformatf("tbl%0d_wr", i), int'(wr), int'(tbl[i].wr));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].done));
      chk($sformatf("tbl%0d_ra", i), int'(ra), tbl[i].ra);
    end
  endtask

  task automatic wait_ra(input int v);
    int n = 0;
    while (int'(ra) != v && n < 4000) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (int'(ra) != v) chk("wait_ra_timeout", int'(ra), v);
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!wr && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!wr) chk("wait_wr_timeout", int'(wr), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("done_reached", int'(done), 1);
    chk("busy_cleared", int'(busy), 0);
  endtask

  task automatic finish_copy(input string tag);
    chk({tag, "_transfers"}, transfers, N);
    chk({tag, "_sb_left"}, sbq.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, int'(wr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ra"}, int'(ra), 0);
    chk({tag, "_wa"}, int'(wa), 0);
    chk({tag, "_wd"}, int'(wd), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    // offsets are rising edges after the start-accepting edge, ack tied high
    tbl[0] = '{0,    1'b0, 1'b1, 1'b0, 0};
    tbl[1] = '{1,    1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{2,    1'b1, 1'b1, 1'b0, 0};
    tbl[3] = '{3,    1'b0, 1'b1, 1'b0, 1};
    tbl[4] = '{5,    1'b1, 1'b1, 1'b0, 1};
    tbl[5] = '{3071, 1'b1, 1'b1, 1'b0, 1023};
    tbl[6] = '{3072, 1'b0, 1'b0, 1'b1, 1023};
    tbl[7] = '{3073, 1'b0, 1'b0, 1'b1, 1023};

    #2;
    chk_zero("reset");

    // start is presented together with reset release: first edge must accept it
    @(posedge clock);
    #1;
    reset = 1'b1;
    start_copy(t0);
    run_table(t0);
    finish_copy("copy1");

    // restart from DONE
    @(posedge clock);
    #1;
    start_copy(t0);
    run_table(t0);
    finish_copy("copy2");

    // ignored start pulses plus back-pressure on byte 7
    @(posedge clock);
    #1;
    start_copy(t0);
    wait_ra(3);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_ra(7);
    ack = 1'b0;
    wait_wr();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      if (k == 5) ack = 1'b1;
      @(negedge clock);
      chk($sformatf("bp%0d_wr", k), int'(wr), 1);
      chk($sformatf("bp%0d_wa", k), int'(wa), int'(BASE) + 7);
      chk($sformatf("bp%0d_wd", k), int'(wd), 7 ^ 8'h5A);
    end
    wait_ra(500);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done();
    finish_copy("copy3");
    chk("byte7_count", byte_cnt[7], 1);
    chk("byte500_count", byte_cnt[500], 1);

    // abort mid-WRITE of byte 100
    @(posedge clock);
    #1;
    start_copy(t0);
    wait_ra(100);
    ack = 1'b0;
    wait_wr();
    #2;
    reset = 1'b0;
    #1;
    chk_zero("abort");
    sbq.delete();
    @(posedge clock);
    #1;
    chk("abort_hold_wr", int'(wr), 0);
    chk("abort_hold_busy", int'(busy), 0);
    reset = 1'b1;
    ack = 1'b1;
    start_copy(t0);
    chk("post_reset_busy", int'(busy), 1);
    chk("post_reset_done", int'(done), 0);
    wait_done();
    finish_copy("copy5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
